// File: rtl/stepper_pkg.sv
// Shared types and constants for the A4988 move sequencer.
package stepper_pkg;

  localparam int STEP_W     = 17;
  localparam int INTERVAL_W = 16;

  // A4988 pin polarities: ENABLE is active-low, SLEEP is active-low.
  localparam logic ENABLE_ON = 1'b0;
  localparam logic AWAKE     = 1'b1;

  typedef enum logic [2:0] {
    ST_SLEEP,
    ST_WAKE,
    ST_IDLE,
    ST_DIR_SETUP,
    ST_PULSE_HI,
    ST_PULSE_LO
  } stepper_state_t;

  function automatic logic tick_last(input logic [31:0] cnt, input logic [31:0] dur);
    return cnt == (dur - 32'd1);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-clk tick strobe every TICK_DIV clocks.
module tick_prescaler #(
  parameter int TICK_DIV = 27
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(TICK_DIV - 1)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = (r_cnt == CW'(TICK_DIV - 1));

endmodule

// File: rtl/stepper_move_sequencer.sv
// Command-driven A4988 sequencer: wake/dir/step sequencing with a symmetric linear ramp.
import stepper_pkg::*;

module stepper_move_sequencer #(
  parameter int TICK_DIV         = 27,
  parameter int WAKE_TICKS       = 1000,
  parameter int DIR_SETUP_TICKS  = 1,
  parameter int PULSE_TICKS      = 2,
  parameter int START_INTERVAL   = 450,
  parameter int MIN_INTERVAL     = 60,
  parameter int IDLE_SLEEP_TICKS = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [STEP_W-1:0]     cmd_steps,
  input  logic                  cmd_dir,
  input  logic [INTERVAL_W-1:0] cmd_interval,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [STEP_W-1:0]     step_count,
  output logic                  motor_pul,
  output logic                  motor_direction,
  output logic                  motor_enable,
  output logic                  A4988_sleep,
  output stepper_state_t        dbg_state
);

  localparam logic [INTERVAL_W-1:0] START_IV = INTERVAL_W'(START_INTERVAL);
  localparam logic [INTERVAL_W-1:0] MIN_IV   = INTERVAL_W'(MIN_INTERVAL);

  logic                  w_tick;
  stepper_state_t        r_state, w_state;
  logic [31:0]           r_tcnt, w_tcnt, w_lo_ticks;
  logic [STEP_W-1:0]     r_steps, w_steps, r_count, w_count, r_ramp, w_ramp, w_rem;
  logic [INTERVAL_W-1:0] r_target, w_target, r_cur, w_cur, w_clamped;
  logic                  r_abort, w_abort, r_done, w_done, r_aborted, w_aborted;
  logic                  r_pul, w_pul, r_dir, w_dir, r_enable, w_enable, r_sleep, w_sleep;
  logic                  w_abort_req;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  always_comb begin
    if (cmd_interval < MIN_IV)        w_clamped = MIN_IV;
    else if (cmd_interval > START_IV) w_clamped = START_IV;
    else                              w_clamped = cmd_interval;
  end

  assign w_rem       = r_steps - r_count;
  assign w_abort_req = r_abort | abort;
  assign w_lo_ticks  = 32'(r_cur) - 32'(PULSE_TICKS);

  // Handshake: a command transfers on the clk edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in SLEEP and IDLE, and the payload is latched on that edge.
  always_comb begin
    w_state   = r_state;
    w_tcnt    = w_tick ? r_tcnt + 32'd1 : r_tcnt;
    w_steps   = r_steps;
    w_count   = r_count;
    w_ramp    = r_ramp;
    w_target  = r_target;
    w_cur     = r_cur;
    w_abort   = r_abort;
    w_done    = 1'b0;
    w_aborted = r_aborted;
    w_pul     = r_pul;
    w_dir     = r_dir;
    w_enable  = r_enable;
    w_sleep   = r_sleep;
    unique case (r_state)
      ST_SLEEP, ST_IDLE: begin
        if (cmd_valid) begin
          w_steps   = cmd_steps;
          w_count   = '0;
          w_target  = w_clamped;
          w_cur     = START_IV;
          w_ramp    = '0;
          w_abort   = 1'b0;
          w_aborted = 1'b0;
          w_tcnt    = '0;
          if (cmd_steps == '0) begin
            w_done = 1'b1;
          end else begin
            w_dir    = cmd_dir;
            w_sleep  = AWAKE;
            w_enable = ENABLE_ON;
            w_state  = (r_state == ST_SLEEP) ? ST_WAKE : ST_DIR_SETUP;
          end
        end else if (r_state == ST_SLEEP) begin
          w_tcnt = '0;
        end else if (IDLE_SLEEP_TICKS != 0 && w_tick &&
                     tick_last(r_tcnt, 32'(IDLE_SLEEP_TICKS))) begin
          w_state  = ST_SLEEP;
          w_sleep  = ~AWAKE;
          w_enable = ~ENABLE_ON;
          w_tcnt   = '0;
        end
      end
      ST_WAKE, ST_DIR_SETUP: begin
        if (abort) begin
          w_state   = ST_IDLE;
          w_done    = 1'b1;
          w_aborted = 1'b1;
          w_tcnt    = '0;
        end else if (r_state == ST_WAKE && w_tick && tick_last(r_tcnt, 32'(WAKE_TICKS))) begin
          w_state = ST_DIR_SETUP;
          w_tcnt  = '0;
        end else if (r_state == ST_DIR_SETUP && w_tick &&
                     tick_last(r_tcnt, 32'(DIR_SETUP_TICKS))) begin
          w_state = ST_PULSE_HI;
          w_pul   = 1'b1;
          w_count = r_count + 17'd1;
          w_tcnt  = '0;
        end
      end
      ST_PULSE_HI: begin
        w_abort = w_abort_req;
        if (w_tick && tick_last(r_tcnt, 32'(PULSE_TICKS))) begin
          w_pul  = 1'b0;
          w_tcnt = '0;
          if (w_abort_req) begin
            w_state   = ST_IDLE;
            w_done    = 1'b1;
            w_aborted = 1'b1;
          end else begin
            w_state = ST_PULSE_LO;
          end
        end
      end
      ST_PULSE_LO: begin
        w_abort = w_abort_req;
        if (w_tick && tick_last(r_tcnt, w_lo_ticks)) begin
          w_tcnt = '0;
          if (r_count == r_steps) begin
            w_state   = ST_IDLE;
            w_done    = 1'b1;
            w_aborted = 1'b0;
          end else begin
            // Accelerate only while the remaining distance leaves room for a
            // matching decel; the midpoint step holds so the profile mirrors.
            if (w_rem <= r_ramp) begin
              if (r_cur < START_IV) w_cur = r_cur + 16'd1;
            end else if (r_cur > r_target && w_rem > r_ramp + 17'd1) begin
              w_cur  = r_cur - 16'd1;
              w_ramp = r_ramp + 17'd1;
            end
            w_state = ST_PULSE_HI;
            w_pul   = 1'b1;
            w_count = r_count + 17'd1;
          end
        end
      end
      default: w_state = ST_SLEEP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_SLEEP;
      r_tcnt    <= '0;
      r_steps   <= '0;
      r_count   <= '0;
      r_ramp    <= '0;
      r_target  <= START_IV;
      r_cur     <= START_IV;
      r_abort   <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_pul     <= 1'b0;
      r_dir     <= 1'b0;
      r_enable  <= ~ENABLE_ON;
      r_sleep   <= ~AWAKE;
    end else begin
      r_state   <= w_state;
      r_tcnt    <= w_tcnt;
      r_steps   <= w_steps;
      r_count   <= w_count;
      r_ramp    <= w_ramp;
      r_target  <= w_target;
      r_cur     <= w_cur;
      r_abort   <= w_abort;
      r_done    <= w_done;
      r_aborted <= w_aborted;
      r_pul     <= w_pul;
      r_dir     <= w_dir;
      r_enable  <= w_enable;
      r_sleep   <= w_sleep;
    end
  end

  assign cmd_ready       = (r_state == ST_SLEEP) || (r_state == ST_IDLE);
  assign busy            = ~cmd_ready;
  assign done            = r_done;
  assign aborted         = r_aborted;
  assign step_count      = r_count;
  assign motor_pul       = r_pul;
  assign motor_direction = r_dir;
  assign motor_enable    = r_enable;
  assign A4988_sleep     = r_sleep;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_stepper_move_sequencer.sv
// Directed bench for stepper_move_sequencer: vector table of moves plus hand sequences.
module tb_stepper_move_sequencer;
  import stepper_pkg::*;

  localparam int WAKE_T  = 20;
  localparam int IDLE_T  = 50;
  localparam int BUDGET  = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [16:0] cmd_steps = '0;
  logic        cmd_dir = 1'b0;
  logic [15:0] cmd_interval = '0;
  logic        abort = 1'b0;
  logic        busy, done, aborted;
  logic [16:0] step_count;
  logic        motor_pul, motor_direction, motor_enable, A4988_sleep;
  stepper_state_t dbg_state;

  stepper_move_sequencer #(
    .TICK_DIV(1), .WAKE_TICKS(WAKE_T), .DIR_SETUP_TICKS(1), .PULSE_TICKS(2),
    .START_INTERVAL(10), .MIN_INTERVAL(5), .IDLE_SLEEP_TICKS(IDLE_T)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_interval(cmd_interval),
    .abort(abort), .busy(busy), .done(done), .aborted(aborted),
    .step_count(step_count), .motor_pul(motor_pul),
    .motor_direction(motor_direction), .motor_enable(motor_enable),
    .A4988_sleep(A4988_sleep), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  typedef struct packed {
    logic [16:0] steps;
    logic        dir;
    logic [15:0] interval;
    logic [7:0]  pre_wait;
    logic [4:0]  abort_at;
    logic [7:0]  exp_lat;
    logic [16:0] exp_count;
    logic        exp_aborted;
  } vec_t;

  vec_t        vecs[9];
  int          per_tab[9][20];
  logic [15:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int steps, input int dir, input int intv, input int pre,
                              input int ab, input int lat, input int cnt, input int abd);
    vec_t v;
    v.steps       = 17'(steps);
    v.dir         = 1'(dir);
    v.interval    = 16'(intv);
    v.pre_wait    = 8'(pre);
    v.abort_at    = 5'(ab);
    v.exp_lat     = 8'(lat);
    v.exp_count   = 17'(cnt);
    v.exp_aborted = 1'(abd);
    return v;
  endfunction

  task automatic check_period(input string tag, input int act);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_extra_pulse"}, act, 0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_period"}, act, int'(e));
    end
  endtask

  // Driver: issue one command, then watch STEP edges until done (bounded).
  task automatic run_move(input string tag, input vec_t v, input int per[20]);
    int   t, rises, last_rise;
    logic prev_pul, done_seen, ab_on;
    exp_q.delete();
    for (int i = 0; i < int'(v.exp_count); i++) exp_q.push_back(16'(per[i]));
    repeat (int'(v.pre_wait)) @(negedge clk);
    chk({tag, "_ready"}, int'(cmd_ready), 1);
    cmd_valid    = 1'b1;
    cmd_steps    = v.steps;
    cmd_dir      = v.dir;
    cmd_interval = v.interval;
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 1; rises = 0; last_rise = 0; prev_pul = 1'b0; done_seen = 1'b0; ab_on = 1'b0;
    while (!done_seen && t < BUDGET) begin
      if (ab_on) begin
        abort = 1'b0;
        ab_on = 1'b0;
      end
      if (motor_pul && !prev_pul) begin
        rises++;
        if (rises == 1) begin
          chk({tag, "_latency"}, t - 1, int'(v.exp_lat));
          chk({tag, "_dir"}, int'(motor_direction), int'(v.dir));
          chk({tag, "_awake"}, int'(A4988_sleep), 1);
          chk({tag, "_enable"}, int'(motor_enable), 0);
          chk({tag, "_busy"}, int'(busy), 1);
        end else begin
          check_period(tag, t - last_rise);
        end
        last_rise = t;
        if (rises == int'(v.abort_at)) begin
          abort = 1'b1;
          ab_on = 1'b1;
        end
      end
      if (done) begin
        done_seen = 1'b1;
        check_period(tag, t - last_rise);
      end
      prev_pul = motor_pul;
      if (!done_seen) begin
        @(negedge clk);
        t++;
      end
    end
    abort = 1'b0;
    chk({tag, "_done_seen"}, int'(done_seen), 1);
    chk({tag, "_pulses"}, rises, int'(v.exp_count));
    chk({tag, "_step_count"}, int'(step_count), int'(v.exp_count));
    chk({tag, "_aborted"}, int'(aborted), int'(v.exp_aborted));
    chk({tag, "_idle_busy"}, int'(busy), 0);
    chk({tag, "_periods_left"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_pul"}, int'(motor_pul), 0);
    chk({tag, "_dir"}, int'(motor_direction), 0);
    chk({tag, "_enable"}, int'(motor_enable), 1);
    chk({tag, "_sleep"}, int'(A4988_sleep), 0);
    chk({tag, "_ready"}, int'(cmd_ready), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_aborted"}, int'(aborted), 0);
    chk({tag, "_count"}, int'(step_count), 0);
  endtask

  initial begin
    int  k;
    bit  saw;
    vecs[0] = mk(20, 1, 5,   1,  0, 21, 20, 0);
    vecs[1] = mk(4,  0, 5,   1,  0, 1,  4,  0);
    vecs[2] = mk(5,  1, 200, 1,  0, 1,  5,  0);
    vecs[3] = mk(7,  0, 7,   1,  0, 1,  7,  0);
    vecs[4] = mk(14, 1, 2,   1,  0, 1,  14, 0);
    vecs[5] = mk(20, 1, 5,   1,  7, 1,  7,  1);
    vecs[6] = mk(2,  0, 5,   1,  0, 1,  2,  0);
    vecs[7] = mk(1,  1, 5,   1,  0, 21, 1,  0);
    vecs[8] = mk(2,  0, 5,   48, 0, 1,  2,  0);
    per_tab[0] = '{10,9,8,7,6, 5,5,5,5,5, 5,5,5,5,5, 6,7,8,9,10};
    per_tab[1] = '{10,9,9,10,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0};
    per_tab[2] = '{10,10,10,10,10, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0};
    per_tab[3] = '{10,9,8,7,8, 9,10,0,0,0, 0,0,0,0,0, 0,0,0,0,0};
    per_tab[4] = '{10,9,8,7,6, 5,5,5,5,6, 7,8,9,10,0, 0,0,0,0,0};
    per_tab[5] = '{10,9,8,7,6, 5,2,0,0,0, 0,0,0,0,0, 0,0,0,0,0};
    per_tab[6] = '{10,10,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0};
    per_tab[7] = '{10,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0};
    per_tab[8] = '{10,10,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0};

    // Reset state, during and after reset
    repeat (3) @(negedge clk);
    check_reset_values("rst_held");
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("rst_released");

    // Table-driven moves: SLEEP start, ramps, clamps, abort, post-abort command
    for (int i = 0; i < 7; i++) begin
      run_move($sformatf("vec%0d", i), vecs[i], per_tab[i]);
    end

    // Auto-sleep exactly IDLE_T ticks after done
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) chk("done_width", int'(done), 0);
    end while (A4988_sleep && k < 200);
    chk("sleep_fall_delay", k, IDLE_T);
    chk("sleep_enable_off", int'(motor_enable), 1);
    chk("sleep_state", int'(dbg_state), int'(ST_SLEEP));

    // Zero-step command in SLEEP: done next cycle, nothing else moves
    cmd_valid = 1'b1;
    cmd_steps = '0;
    cmd_dir   = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("zero_done", int'(done), 1);
    chk("zero_aborted", int'(aborted), 0);
    chk("zero_state", int'(dbg_state), int'(ST_SLEEP));
    chk("zero_sleep", int'(A4988_sleep), 0);
    chk("zero_pul", int'(motor_pul), 0);
    @(negedge clk);
    chk("zero_done_width", int'(done), 0);

    // Wake from SLEEP, then a command at idle tick 49 keeps it awake and skips WAKE
    run_move("wake1", vecs[7], per_tab[7]);
    run_move("tick49", vecs[8], per_tab[8]);

    // Asynchronous reset while STEP is high
    @(negedge clk);
    cmd_valid    = 1'b1;
    cmd_steps    = 17'd20;
    cmd_dir      = 1'b1;
    cmd_interval = 16'd5;
    @(negedge clk);
    cmd_valid = 1'b0;
    saw = 1'b0;
    for (int c = 0; c < BUDGET && !saw; c++) begin
      if (motor_pul) saw = 1'b1;
      else @(negedge clk);
    end
    chk("rst_mid_saw_pulse", int'(saw), 1);
    rst = 1'b1;
    #1;
    check_reset_values("rst_mid");
    @(negedge clk);
    chk("rst_mid_no_done", int'(done), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_state", int'(dbg_state), int'(ST_SLEEP));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
